fft_frame_sched: RTL and testbench
==================================

// Module: fft_frame_sched
// PURPOSE
//  Frame-level scheduler for the FFT pipeline. It counts incoming sample beats
//  into frames and commits only complete frames. For each committed frame it
//  issues a staggered one-cycle start pulse to every stage controller (the
//  en inputs of the per-stage ctrl_mod* blocks), then frames the pipeline
//  output window. It also tracks completed frames and flags broken input frames.
// PARAMETERS
//  NUM_STAGE  3   number of pipeline stages / stage_en pulses per frame
//  FRAME_LEN  32  din_valid beats per frame (>=2)
//  STAGE_DLY  16  cycles between consecutive stage_en pulses (>=1)
//  FCNT_W     8   width of frame_cnt (wraps)
// PORTS
//  clk        in   1          clock, all logic on posedge
//  rst        in   1          asynchronous, active-high reset
//  din_valid  in   1          input sample beat valid
//  flush      in   1          synchronous abort of all in-flight work
//  err_clr    in   1          clears err_gap
//  stage_en   out  NUM_STAGE  one-cycle start pulse per stage, bit s = stage s
//  dout_valid out  1          pipeline output window, FRAME_LEN cycles per frame
//  dout_last  out  1          high on final dout_valid cycle of a frame
//  frame_cnt  out  FCNT_W     completed output frames, wraps at 2^FCNT_W
//  busy       out  1          any frame partially received or in flight
//  err_gap    out  1          sticky: din_valid dropped mid-frame
// BEHAVIOUR
//  Reset: clk and rst only. On rst high, asynchronously clear every output,
//   in_cnt, the token delay line and out_cnt to 0.
//  Input counter: in_cnt counts 0..FRAME_LEN-1.
//   - din_valid=1: in_cnt increments.
//   - in_cnt=FRAME_LEN-1 with din_valid=1: frame commits and in_cnt wraps to 0.
//   - Back-to-back frames need no idle cycle: the next din_valid beat is beat 0.
//  Gap: din_valid=0 while in_cnt!=0 aborts the partial frame.
//   - in_cnt returns to 0; err_gap is set on the next cycle.
//   - No stage_en is issued for the aborted frame.
//   - din_valid=0 with in_cnt=0 is idle, not an error.
//  Timing (all outputs registered). First beat of a committed frame at cycle T, C=T+FRAME_LEN:
//   - stage_en[s] is high for exactly cycle C+s*STAGE_DLY.
//   - dout_valid is high for cycles D..D+FRAME_LEN-1, where D=C+NUM_STAGE*STAGE_DLY.
//   - dout_last is high at D+FRAME_LEN-1.
//   - frame_cnt increments at D+FRAME_LEN and wraps modulo 2^FCNT_W.
//  Implementation: commit token shifts through a NUM_STAGE*STAGE_DLY-deep delay line.
//   - stage_en taps sit at multiples of STAGE_DLY.
//   - The line end starts out_cnt, which counts 0..FRAME_LEN-1.
//   - Commits are >=FRAME_LEN apart, so output windows never overlap.
//   - Consecutive windows may abut, giving dout_valid continuously high.
//  busy = (in_cnt!=0) | any token in the delay line | dout_valid.
//   It is combinational from registers, with no extra latency.
//  flush=1 clears in_cnt, the delay line and out_cnt on the next edge.
//   - stage_en, dout_valid and dout_last are low from the next cycle.
//   - frame_cnt and err_gap are held.
//   - A din_valid beat in the same cycle is ignored (flush wins).
//  err_clr=1 clears err_gap, except when a new gap occurs in the same cycle;
//   then err_gap stays 1 (set wins).
//  Reset mid-frame: all state is lost immediately and no pulse is issued
//   after rst deasserts.
// TESTING
//  1 Single frame: din_valid high cycles 0..31 ->
//     stage_en = 001 @32, 010 @48, 100 @64; dout_valid 80..111; dout_last @111;
//     frame_cnt=1 @112; busy high 1..111, low @112.
//  2 Back-to-back: din_valid high cycles 0..63 ->
//     stage_en[0] @32 and @64; dout_valid continuous 80..143;
//     dout_last @111 and @143; frame_cnt=2 @144.
//  3 Gap: din_valid high 0..9, low @10, high 11..42 ->
//     err_gap=1 @11; a single frame commits, stage_en[0] @43; frame_cnt=1 @123.
//  4 Flush: single frame, flush=1 @50 ->
//     stage_en[2] never fires; dout_valid never rises; busy=0 @51; frame_cnt stays 0.
//  5 err_clr and gap in the same cycle keep err_gap=1; err_clr alone -> err_gap=0 next cycle.
//  6 Async rst pulse at cycle 70 of test 1 -> all outputs 0 immediately;
//     no dout_valid afterwards; frame_cnt=0.

Source files
------------

// File: rtl/fft_frame_sched.sv
// Frame-level scheduler for the FFT pipeline.
// Counts din_valid beats into frames, commits only complete frames, and for
// each commit emits a staggered start pulse per stage controller followed by
// a FRAME_LEN-cycle output window. Tracks completed frames and flags gaps.
//
// Output window FSM
//   state    | meaning
//   OUT_IDLE | no output window active
//   OUT_RUN  | dout_valid high, out_cnt walks 0..FRAME_LEN-1
module fft_frame_sched #(
   parameter int NUM_STAGE = 3,
   parameter int FRAME_LEN = 32,
   parameter int STAGE_DLY = 16,
   parameter int FCNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din_valid,
   input  logic                 flush,
   input  logic                 err_clr,
   output logic [NUM_STAGE-1:0] stage_en,
   output logic                 dout_valid,
   output logic                 dout_last,
   output logic [FCNT_W-1:0]    frame_cnt,
   output logic                 busy,
   output logic                 err_gap
);

   localparam int CW     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int DL_LEN = NUM_STAGE * STAGE_DLY;
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

   typedef enum logic {
      OUT_IDLE = 1'b0,
      OUT_RUN  = 1'b1
   } out_state_t;

   out_state_t        out_state, out_state_nxt;
   logic [CW-1:0]     in_cnt;
   logic [CW-1:0]     out_cnt, out_cnt_nxt;
   logic              dout_last_nxt;
   logic [DL_LEN-1:0] tok_dl;
   logic              commit;
   logic              gap;

   // flush overrides both a completing beat and a gap in the same cycle
   assign commit = din_valid & ~flush & (in_cnt == CNT_LAST);
   assign gap    = ~din_valid & ~flush & (in_cnt != '0);

   // input beat counter; any abort or commit returns it to beat 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_cnt <= '0;
      end else if (flush || gap || commit) begin
         in_cnt <= '0;
      end else if (din_valid) begin
         in_cnt <= in_cnt + CW'(1);
      end
   end

   // commit token delay line; bit 0 is high the cycle after the last beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tok_dl <= '0;
      end else if (flush) begin
         tok_dl <= '0;
      end else begin
         tok_dl <= (tok_dl << 1) | DL_LEN'(commit);
      end
   end

   // stage start pulses are direct taps of the token line
   always_comb begin
      stage_en = '0;
      for (int s = 0; s < NUM_STAGE; s++) begin
         stage_en[s] = tok_dl[s*STAGE_DLY];
      end
   end

   // output window state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_state <= OUT_IDLE;
         out_cnt   <= '0;
         dout_last <= 1'b0;
      end else begin
         out_state <= out_state_nxt;
         out_cnt   <= out_cnt_nxt;
         dout_last <= dout_last_nxt;
      end
   end

   // output window next state; a token at the line end may restart an
   // ending window so consecutive frames abut without a bubble
   always_comb begin
      out_state_nxt = out_state;
      out_cnt_nxt   = out_cnt;
      if (flush) begin
         out_state_nxt = OUT_IDLE;
         out_cnt_nxt   = '0;
      end else if (tok_dl[DL_LEN-1]) begin
         out_state_nxt = OUT_RUN;
         out_cnt_nxt   = '0;
      end else if (out_state == OUT_RUN) begin
         if (out_cnt == CNT_LAST) begin
            out_state_nxt = OUT_IDLE;
            out_cnt_nxt   = '0;
         end else begin
            out_cnt_nxt = out_cnt + CW'(1);
         end
      end
      dout_last_nxt = (out_state_nxt == OUT_RUN) && (out_cnt_nxt == CNT_LAST);
   end

   assign dout_valid = (out_state == OUT_RUN);

   // completed-frame counter, bumped the cycle after dout_last
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (dout_last && !flush) begin
         frame_cnt <= frame_cnt + FCNT_W'(1);
      end
   end

   // sticky gap flag; a new gap beats a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_gap <= 1'b0;
      end else if (gap) begin
         err_gap <= 1'b1;
      end else if (err_clr) begin
         err_gap <= 1'b0;
      end
   end

   assign busy = (in_cnt != '0) | (|tok_dl) | dout_valid;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Self-checking bench for fft_frame_sched: directed scenarios plus random
// beat/flush/err_clr traffic against a frame-level reference model.
module tb_fft_frame_sched;

   localparam int NS = 3;
   localparam int FL = 32;
   localparam int SD = 16;
   localparam int FW = 8;
   localparam int L  = NS * SD;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          din_valid = 1'b0;
   logic          flush = 1'b0;
   logic          err_clr = 1'b0;
   logic [NS-1:0] stage_en;
   logic          dout_valid;
   logic          dout_last;
   logic [FW-1:0] frame_cnt;
   logic          busy;
   logic          err_gap;

   always #5 clk = ~clk;

   fft_frame_sched #(
      .NUM_STAGE(NS),
      .FRAME_LEN(FL),
      .STAGE_DLY(SD),
      .FCNT_W(FW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .din_valid(din_valid),
      .flush(flush),
      .err_clr(err_clr),
      .stage_en(stage_en),
      .dout_valid(dout_valid),
      .dout_last(dout_last),
      .frame_cnt(frame_cnt),
      .busy(busy),
      .err_gap(err_gap)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // reference model: beats in the current partial frame, commit cycles of
   // frames still in flight, completed frame count, sticky gap flag
   int m_in   = 0;
   bit m_err  = 1'b0;
   int m_fcnt = 0;
   int q[$];

   // first-occurrence event log relative to t0 (-1 = never seen)
   int t0 = 0;
   int ev_se[NS];
   int ev_dv, ev_last, ev_fc, ev_err, ev_busy0;
   logic [FW-1:0] fc0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   task automatic clr_ev();
      t0 = cyc;
      for (int s = 0; s < NS; s++) ev_se[s] = -1;
      ev_dv = -1; ev_last = -1; ev_fc = -1; ev_err = -1; ev_busy0 = -1;
      fc0 = frame_cnt;
   endtask

   task automatic model_reset();
      m_in = 0; m_err = 1'b0; m_fcnt = 0;
      q.delete();
   endtask

   // drive one cycle of inputs, check outputs of this cycle, advance model
   task automatic step(input bit dv, input bit fl, input bit ec);
      logic [NS-1:0] e_se;
      bit e_dv, e_dl, g;
      int d, rel;
      din_valid = dv; flush = fl; err_clr = ec;
      @(negedge clk);
      while (q.size() > 0 && q[0] + L + FL <= cyc) begin
         void'(q.pop_front());
         m_fcnt++;
      end
      e_se = '0; e_dv = 1'b0; e_dl = 1'b0;
      foreach (q[i]) begin
         for (int s = 0; s < NS; s++)
            if (cyc == q[i] + s * SD) e_se[s] = 1'b1;
         d = q[i] + L;
         if (cyc >= d && cyc < d + FL) e_dv = 1'b1;
         if (cyc == d + FL - 1) e_dl = 1'b1;
      end
      chk("stage_en", 32'(stage_en), 32'(e_se));
      chk("dout_valid", 32'(dout_valid), 32'(e_dv));
      chk("dout_last", 32'(dout_last), 32'(e_dl));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt % (1 << FW)));
      chk("busy", 32'(busy), 32'((m_in != 0) || (q.size() != 0)));
      chk("err_gap", 32'(err_gap), 32'(m_err));
      rel = cyc - t0;
      for (int s = 0; s < NS; s++)
         if (stage_en[s] && ev_se[s] < 0) ev_se[s] = rel;
      if (dout_valid && ev_dv < 0) ev_dv = rel;
      if (dout_last && ev_last < 0) ev_last = rel;
      if (frame_cnt != fc0 && ev_fc < 0) ev_fc = rel;
      if (err_gap && ev_err < 0) ev_err = rel;
      if (!busy && rel > 0 && ev_busy0 < 0) ev_busy0 = rel;
      if (fl) begin
         m_in = 0;
         q.delete();
         if (ec) m_err = 1'b0;
      end else begin
         g = !dv && (m_in != 0);
         if (dv) begin
            m_in++;
            if (m_in == FL) begin
               q.push_back(cyc + 1);
               m_in = 0;
            end
         end
         if (g) m_in = 0;
         if (g) m_err = 1'b1;
         else if (ec) m_err = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   int n, r, fc_before;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stage_en", 32'(stage_en), 32'd0);
      chk("rst_dout_valid", 32'(dout_valid), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      cyc = 0;

      // single frame
      clr_ev();
      repeat (32) step(1, 0, 0);
      repeat (90) step(0, 0, 0);
      chk("t1_se0", ev_se[0], 32);
      chk("t1_se1", ev_se[1], 48);
      chk("t1_se2", ev_se[2], 64);
      chk("t1_dv", ev_dv, 80);
      chk("t1_last", ev_last, 111);
      chk("t1_fc", ev_fc, 112);
      chk("t1_busy0", ev_busy0, 112);

      // back-to-back frames
      clr_ev();
      repeat (64) step(1, 0, 0);
      repeat (100) step(0, 0, 0);
      chk("t2_se0", ev_se[0], 32);
      chk("t2_last", ev_last, 111);
      chk("t2_fcnt", 32'(frame_cnt), 32'(3));

      // gap
      clr_ev();
      repeat (10) step(1, 0, 0);
      step(0, 0, 0);
      repeat (32) step(1, 0, 0);
      repeat (100) step(0, 0, 0);
      chk("t3_err", ev_err, 11);
      chk("t3_se0", ev_se[0], 43);
      chk("t3_fc", ev_fc, 123);
      step(0, 0, 1);

      // flush mid-flight
      clr_ev();
      repeat (32) step(1, 0, 0);
      repeat (18) step(0, 0, 0);
      step(0, 1, 0);
      repeat (80) step(0, 0, 0);
      chk("t4_se2", ev_se[2], -1);
      chk("t4_dv", ev_dv, -1);
      chk("t4_fc", ev_fc, -1);
      chk("t4_busy0", ev_busy0, 51);

      // err_clr vs gap
      repeat (5) step(1, 0, 0);
      step(0, 0, 0);
      repeat (5) step(1, 0, 0);
      step(0, 0, 1);
      chk("t5_keep", 32'(err_gap), 32'd1);
      step(0, 0, 1);
      chk("t5_clr", 32'(err_gap), 32'd0);

      // async reset mid-frame
      clr_ev();
      repeat (32) step(1, 0, 0);
      repeat (38) step(0, 0, 0);
      rst = 1'b1;
      #1;
      chk("t6_stage_en", 32'(stage_en), 32'd0);
      chk("t6_dout_valid", 32'(dout_valid), 32'd0);
      chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc++;
      clr_ev();
      repeat (100) step(0, 0, 0);
      chk("t6_dv", ev_dv, -1);

      // random traffic
      n = 0;
      while (n < 3000) begin
         r = $urandom_range(0, 9);
         if (r < 6) begin
            repeat (FL * $urandom_range(1, 3)) begin
               step(1, ($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0));
               n++;
            end
         end else if (r < 8) begin
            repeat ($urandom_range(1, FL - 1)) begin
               step(1, 1'b0, ($urandom_range(0, 19) == 0));
               n++;
            end
         end
         repeat ($urandom_range(0, 5)) begin
            step(0, ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0));
            n++;
         end
      end
      repeat (150) step(0, 0, 0);

      // frame counter wrap
      fc_before = int'(frame_cnt);
      repeat (260 * FL) step(1, 0, 0);
      repeat (120) step(0, 0, 0);
      chk("wrap_fcnt", 32'(frame_cnt), 32'((fc_before + 260) % (1 << FW)));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
